// File: rtl/cpu_cycle_sequencer_if.sv
// Instruction-cycle sequencer bus: fetched word and handshake inputs, phase strobes out.
// The sequencer drives the strobes through the master modport; bus control observes via slave.
interface cpu_cycle_sequencer_if;
  logic [15:0] iw;
  logic        wait_req;
  logic        int_req;
  logic        if_stb;
  logic        idxf;
  logic        mem;
  logic        ex;
  logic        intack;
  logic        iw6;
  logic        op_dst;
  logic        int_seq;
  logic        done;

  modport master (
    input  iw, wait_req, int_req,
    output if_stb, idxf, mem, ex, intack, iw6, op_dst, int_seq, done
  );

  modport slave (
    output iw, wait_req, int_req,
    input  if_stb, idxf, mem, ex, intack, iw6, op_dst, int_seq, done
  );
endinterface

// File: rtl/cpu_cycle_sequencer.sv
// Instruction-cycle FSM: decodes the fetched word and sequences the IF/IdxF/Mem/Ex/INTACK
// phase strobes, including reset-vector fetch and interrupt entry.
//
// state    | meaning
// RST_VEC  | reset vector fetch (INTACK), held silent while reset is asserted
// FETCH    | instruction fetch (IF), word latched on exit
// SRC_IDX  | source extension word fetch
// SRC_MEM  | source operand read
// DST_IDX  | destination extension word fetch
// DST_MEM  | destination operand read
// EXEC     | execute / write-back, Done pulse
// INT_PC   | interrupt entry: push PC
// INT_SR   | interrupt entry: push SR
// INT_VEC  | interrupt vector fetch
module cpu_cycle_sequencer (
  input logic                   mclk_i,
  input logic                   reset_i,
  cpu_cycle_sequencer_if.master seq_io
);

  typedef enum logic [3:0] {
    ST_RST_VEC, ST_FETCH, ST_SRC_IDX, ST_SRC_MEM, ST_DST_IDX,
    ST_DST_MEM, ST_EXEC, ST_INT_PC, ST_INT_SR, ST_INT_VEC
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] iw_q, iw_d;
  logic        iw6_q, iw6_d;
  logic        hold_q, hold_d;

  function automatic logic is_jump(input logic [15:0] w);
    return w[15:13] == 3'b001;
  endfunction

  function automatic logic is_fmt1(input logic [15:0] w);
    return w[15:12] >= 4'd4;
  endfunction

  function automatic logic [3:0] src_reg(input logic [15:0] w);
    return is_fmt1(w) ? w[11:8] : w[3:0];
  endfunction

  // Undefined fmt II opcodes fall through here with no source cycles.
  function automatic logic src_skip(input logic [15:0] w);
    logic active;
    logic [3:0] r;
    active = is_fmt1(w) || (w[15:10] == 6'b000100);
    r      = src_reg(w);
    return !active || (w[5:4] == 2'b00) || (r == 4'd3) || ((r == 4'd2) && w[5]);
  endfunction

  function automatic logic src_idx(input logic [15:0] w);
    return !src_skip(w) && ((w[5:4] == 2'b01) || ((w[5:4] == 2'b11) && (src_reg(w) == 4'd0)));
  endfunction

  function automatic logic src_mem(input logic [15:0] w);
    return !src_skip(w) && !((w[5:4] == 2'b11) && (src_reg(w) == 4'd0));
  endfunction

  function automatic logic has_dst(input logic [15:0] w);
    return is_fmt1(w) && w[7];
  endfunction

  function automatic logic dst_mem(input logic [15:0] w);
    return has_dst(w) && (w[15:12] != 4'd4);
  endfunction

  function automatic state_e after_src(input logic [15:0] w);
    return has_dst(w) ? ST_DST_IDX : ST_EXEC;
  endfunction

  always_ff @(posedge mclk_i) begin
    if (reset_i) begin
      state_q <= ST_RST_VEC;
      iw_q    <= '0;
      iw6_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      iw_q    <= iw_d;
      iw6_q   <= iw6_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iw_d    = iw_q;
    iw6_d   = iw6_q;
    hold_d  = hold_q;

    if (!seq_io.wait_req) begin
      hold_d = 1'b0;
      unique case (state_q)
        ST_RST_VEC: if (!hold_q) state_d = ST_FETCH;
        ST_FETCH: begin
          iw_d  = seq_io.iw;
          iw6_d = seq_io.iw[6] & ~is_jump(seq_io.iw);
          if (is_jump(seq_io.iw))      state_d = ST_EXEC;
          else if (src_idx(seq_io.iw)) state_d = ST_SRC_IDX;
          else if (src_mem(seq_io.iw)) state_d = ST_SRC_MEM;
          else                         state_d = after_src(seq_io.iw);
        end
        ST_SRC_IDX: state_d = src_mem(iw_q) ? ST_SRC_MEM : after_src(iw_q);
        ST_SRC_MEM: state_d = after_src(iw_q);
        ST_DST_IDX: state_d = dst_mem(iw_q) ? ST_DST_MEM : ST_EXEC;
        ST_DST_MEM: state_d = ST_EXEC;
        ST_EXEC:    state_d = seq_io.int_req ? ST_INT_PC : ST_FETCH;
        ST_INT_PC:  state_d = ST_INT_SR;
        ST_INT_SR:  state_d = ST_INT_VEC;
        ST_INT_VEC: state_d = ST_FETCH;
        default:    state_d = ST_RST_VEC;
      endcase
    end

    seq_io.if_stb  = 1'b0;
    seq_io.idxf    = 1'b0;
    seq_io.mem     = 1'b0;
    seq_io.ex      = 1'b0;
    seq_io.intack  = 1'b0;
    seq_io.op_dst  = 1'b0;
    seq_io.int_seq = 1'b0;
    seq_io.done    = 1'b0;
    seq_io.iw6     = iw6_q;

    // hold_q keeps RST_VEC silent until the first cycle after reset release.
    if (!hold_q) begin
      unique case (state_q)
        ST_RST_VEC: seq_io.intack = 1'b1;
        ST_FETCH:   seq_io.if_stb = 1'b1;
        ST_SRC_IDX: seq_io.idxf   = 1'b1;
        ST_SRC_MEM: seq_io.mem    = 1'b1;
        ST_DST_IDX: begin seq_io.idxf = 1'b1; seq_io.op_dst = 1'b1; end
        ST_DST_MEM: begin seq_io.mem  = 1'b1; seq_io.op_dst = 1'b1; end
        ST_EXEC:    begin seq_io.ex   = 1'b1; seq_io.done   = 1'b1; end
        ST_INT_PC:  begin seq_io.ex   = 1'b1; seq_io.int_seq = 1'b1; end
        ST_INT_SR:  begin seq_io.ex   = 1'b1; seq_io.int_seq = 1'b1; end
        ST_INT_VEC: begin seq_io.intack = 1'b1; seq_io.int_seq = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Directed bench for cpu_cycle_sequencer: expected strobe vectors are queued per instruction
// and popped one per cycle on the falling edge.
module tb_cpu_cycle_sequencer;

  logic mclk  = 1'b0;
  logic reset = 1'b1;
  always #5 mclk = ~mclk;

  cpu_cycle_sequencer_if sif ();

  cpu_cycle_sequencer dut (
    .mclk_i (mclk),
    .reset_i(reset),
    .seq_io (sif)
  );

  // {IF, IdxF, Mem, Ex, INTACK, IW6, OpDst, IntSeq, Done}
  localparam logic [8:0] O_IF   = 9'h100;
  localparam logic [8:0] O_IDX  = 9'h080;
  localparam logic [8:0] O_MEM  = 9'h040;
  localparam logic [8:0] O_EX   = 9'h020;
  localparam logic [8:0] O_ACK  = 9'h010;
  localparam logic [8:0] O_B    = 9'h008;
  localparam logic [8:0] O_DST  = 9'h004;
  localparam logic [8:0] O_INT  = 9'h002;
  localparam logic [8:0] O_DONE = 9'h001;
  localparam logic [8:0] O_NONE = 9'h000;

  logic [8:0] obs_v;
  assign obs_v = {sif.if_stb, sif.idxf, sif.mem, sif.ex, sif.intack,
                  sif.iw6, sif.op_dst, sif.int_seq, sif.done};

  logic [8:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic push(input logic [8:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag);
    logic [8:0] e;
    @(negedge mclk);
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: observed %b but scoreboard is empty", tag, obs_v);
    end else begin
      e = exp_q.pop_front();
      assert (obs_v === e) else begin
        miscompares++;
        $error("FAIL %s: observed %b expected %b", tag, obs_v, e);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sif.iw       = 16'h0000;
    sif.wait_req = 1'b0;
    sif.int_req  = 1'b0;

    // Reset held two cycles, then the vector fetch.
    push(O_NONE); push(O_NONE);
    chk("reset_c0"); chk("reset_c1");
    reset = 1'b0;
    push(O_ACK);
    chk("rst_vec");

    // MOV #imm,R15: immediate source only.
    sif.iw = 16'h403F;
    push(O_IF); push(O_IDX); push(O_EX | O_DONE);
    repeat (3) chk("mov_imm");

    // ADD 2(R1),x(R6): indexed source and destination.
    sif.iw = 16'h5196;
    push(O_IF); push(O_IDX); push(O_MEM);
    push(O_IDX | O_DST); push(O_MEM | O_DST); push(O_EX | O_DONE);
    repeat (6) chk("add_idx_idx");

    // JEQ with interrupt taken at Ex; IntReq stays high through entry and is ignored.
    sif.iw = 16'h2400;
    push(O_IF);
    chk("jeq_if");
    sif.int_req = 1'b1;
    push(O_EX | O_DONE); push(O_EX | O_INT); push(O_EX | O_INT); push(O_ACK | O_INT);
    repeat (4) chk("jeq_int");
    sif.int_req = 1'b0;

    // MOV.B @R12,R13 with three wait cycles in SRC_MEM.
    sif.iw = 16'h4C6D;
    push(O_IF); push(O_MEM | O_B);
    chk("movb_if"); chk("movb_mem");
    sif.wait_req = 1'b1;
    push(O_MEM | O_B); push(O_MEM | O_B); push(O_MEM | O_B);
    repeat (3) chk("movb_wait");
    sif.wait_req = 1'b0;
    push(O_EX | O_DONE | O_B);
    chk("movb_ex");

    // Jump forces IW6 back to 0.
    sif.iw = 16'h2400;
    push(O_IF | O_B); push(O_EX | O_DONE);
    repeat (2) chk("jeq_iw6");

    // Undefined opcode with As=11/R0 bits: no source cycles, IW6 follows IW[6].
    sif.iw = 16'h0C70;
    push(O_IF); push(O_EX | O_DONE | O_B);
    repeat (2) chk("undef");

    // Format II indirect autoincrement: one operand read.
    sif.iw = 16'h1235;
    push(O_IF | O_B); push(O_MEM); push(O_EX | O_DONE);
    repeat (3) chk("fmt2_ind");

    // Constant-generator source, MOV to indexed destination: no DST_MEM.
    sif.iw = 16'h4392;
    push(O_IF); push(O_IDX | O_DST); push(O_EX | O_DONE);
    repeat (3) chk("mov_cg_dst");

    // Reset in DST_IDX abandons the instruction.
    sif.iw = 16'h5196;
    push(O_IF); push(O_IDX); push(O_MEM); push(O_IDX | O_DST);
    repeat (4) chk("add_pre_rst");
    reset = 1'b1;
    push(O_NONE);
    chk("mid_reset");
    reset = 1'b0;
    push(O_ACK);
    chk("rst_vec2");
    push(O_IF);
    chk("fetch_after_rst");

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
